multicycle_ctrl: RTL and testbench

Control state machine for the multi-cycle build of the core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the enables and selects of the shared datapath: PC, instruction register, immediate generator, ALU operand muxes, register file and writeback mux. It also runs the req/ready handshakes to instruction and data memory.

---
 rtl/multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle core: fetch/decode/exec/mem/wb sequencing and memory handshakes.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to trap on unlisted opcodes instead of treating them as NOPs.
package riscv_pkg;
  parameter int XLEN = 32;
  typedef logic [6:0] opcode_t;
  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_I_TYPE = 7'b0010011;
  localparam opcode_t OP_AUIPC  = 7'b0010111;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_R_TYPE = 7'b0110011;
  localparam opcode_t OP_LUI    = 7'b0110111;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_JALR   = 7'b1100111;
  localparam opcode_t OP_JAL    = 7'b1101111;
endpackage

module multicycle_ctrl #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  riscv_pkg::opcode_t opcode,
  input  logic              branch_taken,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [2:0]        imm_sel,
  output logic              alu_a_sel,
  output logic              alu_b_sel,
  output logic              rf_we,
  output logic [1:0]        wb_sel,
  output logic              instr_done,
  output logic              illegal
);
  import riscv_pkg::*;

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("multicycle_ctrl: unsupported XLEN %0d", XLEN);
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
  } state_t;
`endif

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_IMM   = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   set_illegal;

  function automatic logic is_listed(input opcode_t op);
    case (op)
      OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_listed = 1'b1;
      default:                           is_listed = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input opcode_t op);
    case (op)
      OP_I_TYPE, OP_LOAD, OP_JALR: imm_of = IMM_I;
      OP_STORE:                    imm_of = IMM_S;
      OP_BRANCH:                   imm_of = IMM_B;
      OP_JAL:                      imm_of = IMM_J;
      OP_LUI, OP_AUIPC:            imm_of = IMM_U;
      default:                     imm_of = IMM_NONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst)              illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
  end

  // Gated so the flag reads 0 during the first reset cycle too.
  assign illegal = illegal_q & ~rst;
`else
  assign illegal = 1'b0;
`endif

  // Outputs decode from state and opcode; reset forces them low in the same cycle.
  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    imm_sel     = IMM_NONE;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we     = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          imm_sel   = imm_of(opcode);
          state_nxt = EXEC;
        end
        EXEC: begin
          imm_sel = imm_of(opcode);
          case (opcode)
            OP_R_TYPE: state_nxt = WB;
            OP_I_TYPE: begin
              alu_b_sel = 1'b1;
              state_nxt = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_b_sel = 1'b1;
              state_nxt = MEM;
            end
            OP_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
              state_nxt = WB;
            end
            OP_LUI: state_nxt = WB;
            OP_BRANCH: begin
              pc_we      = 1'b1;
              pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
              instr_done = 1'b1;
              state_nxt  = FETCH;
            end
            OP_JAL: begin
              rf_we      = 1'b1;
              wb_sel     = WB_PC4;
              pc_we      = 1'b1;
              pc_sel     = PC_IMM;
              instr_done = 1'b1;
              state_nxt  = FETCH;
            end
            OP_JALR: begin
              alu_b_sel  = 1'b1;
              rf_we      = 1'b1;
              wb_sel     = WB_PC4;
              pc_we      = 1'b1;
              pc_sel     = PC_ALU;
              instr_done = 1'b1;
              state_nxt  = FETCH;
            end
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
              set_illegal = 1'b1;
              state_nxt   = TRAP;
`else
              state_nxt   = WB;
`endif
            end
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OP_STORE);
          if (dmem_ready) begin
            if (opcode == OP_STORE) begin
              pc_we      = 1'b1;
              pc_sel     = PC_PLUS4;
              instr_done = 1'b1;
              state_nxt  = FETCH;
            end else begin
              state_nxt  = WB;
            end
          end
        end
        WB: begin
          rf_we      = is_listed(opcode);
          wb_sel     = (opcode == OP_LOAD) ? WB_MEM :
                       (opcode == OP_LUI)  ? WB_IMM : WB_ALU;
          pc_we      = 1'b1;
          pc_sel     = PC_PLUS4;
          instr_done = 1'b1;
          state_nxt  = FETCH;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        TRAP: state_nxt = TRAP;
`endif
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized transaction-level bench for multicycle_ctrl against a per-instruction reference model.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  opcode_t    opcode;
  logic       branch_taken;
  logic       imem_req, imem_ready;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       ir_we, pc_we;
  logic [1:0] pc_sel;
  logic [2:0] imm_sel;
  logic       alu_a_sel, alu_b_sel, rf_we;
  logic [1:0] wb_sel;
  logic       instr_done, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cycles; int ireq; int dreq; int dwe; int rf; int wb;
    int psel;   int imm;  int asel; int bsel; int pcwe; int overlap;
  } txn_t;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected per-instruction totals, derived from the instruction class and wait counts.
  function automatic txn_t model(input opcode_t op, input logic bt, input int wi, input int wd);
    txn_t e = '{default: 0};
    e.ireq = wi + 1;
    e.pcwe = 1;
    case (op)
      OP_R_TYPE: begin e.cycles = 4; e.rf = 1; end
      OP_I_TYPE: begin e.cycles = 4; e.rf = 1; e.imm = 1; e.bsel = 1; end
      OP_LOAD:   begin e.cycles = 5 + wd; e.dreq = wd + 1; e.rf = 1; e.wb = 1; e.imm = 1; e.bsel = 1; end
      OP_STORE:  begin e.cycles = 4 + wd; e.dreq = wd + 1; e.dwe = wd + 1; e.imm = 2; e.bsel = 1; end
      OP_BRANCH: begin e.cycles = 3; e.imm = 3; e.psel = bt ? 1 : 0; end
      OP_JAL:    begin e.cycles = 3; e.rf = 1; e.wb = 2; e.psel = 1; e.imm = 4; end
      OP_JALR:   begin e.cycles = 3; e.rf = 1; e.wb = 2; e.psel = 2; e.imm = 1; e.bsel = 1; end
      OP_LUI:    begin e.cycles = 4; e.rf = 1; e.wb = 3; e.imm = 5; end
      OP_AUIPC:  begin e.cycles = 4; e.rf = 1; e.imm = 5; e.asel = 1; e.bsel = 1; end
      default:   e.cycles = 4;
    endcase
    e.cycles += wi;
    return e;
  endfunction

  task automatic run_instr(input opcode_t op, input logic bt, input int wi, input int wd,
                           output txn_t obs, output bit done);
    int ir_cyc = -100;
    obs  = '{default: 0};
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        opcode       = op;
        branch_taken = bt;
      end
      imem_ready = imem_req ? (obs.ireq == wi) : 1'($urandom % 2);
      dmem_ready = dmem_req ? (obs.dreq == wd) : 1'($urandom % 2);
      #1;
      obs.cycles++;
      if (imem_req) obs.ireq++;
      if (dmem_req) obs.dreq++;
      if (dmem_we)  obs.dwe++;
      if (rf_we) begin obs.rf++; obs.wb = int'(wb_sel); end
      if (rf_we && dmem_we) obs.overlap++;
      if (pc_we) begin obs.pcwe++; obs.psel = int'(pc_sel); end
      if (ir_we) ir_cyc = c;
      if (c == ir_cyc + 1) obs.imm = int'(imm_sel);
      if (c == ir_cyc + 2) begin obs.asel = int'(alu_a_sel); obs.bsel = int'(alu_b_sel); end
      if (instr_done) begin
        done = 1'b1;
        if (!pc_we) obs.pcwe = 99;
      end
    end
  endtask

  task automatic check_instr(input opcode_t op, input logic bt, input int wi, input int wd);
    txn_t obs, exp;
    bit   done;
    string p;
    p = $sformatf("op%02h_w%0d%0d", op, wi, wd);
    run_instr(op, bt, wi, wd, obs, done);
    exp = model(op, bt, wi, wd);
    check({p, "_retired"}, 32'(done), 1);
    check({p, "_cycles"},  obs.cycles, exp.cycles);
    check({p, "_imem_req"}, obs.ireq, exp.ireq);
    check({p, "_dmem_req"}, obs.dreq, exp.dreq);
    check({p, "_dmem_we"}, obs.dwe, exp.dwe);
    check({p, "_rf_we"},   obs.rf, exp.rf);
    check({p, "_wb_sel"},  obs.wb, exp.wb);
    check({p, "_pc_sel"},  obs.psel, exp.psel);
    check({p, "_pc_we"},   obs.pcwe, exp.pcwe);
    check({p, "_imm_sel"}, obs.imm, exp.imm);
    check({p, "_alu_a"},   obs.asel, exp.asel);
    check({p, "_alu_b"},   obs.bsel, exp.bsel);
    check({p, "_overlap"}, obs.overlap, 0);
    check({p, "_illegal"}, 32'(illegal), 0);
  endtask

  initial begin
    opcode_t legal [9] = '{OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH,
                           OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    opcode_t odd [4] = '{7'h00, 7'h7f, 7'h0f, 7'h73};
    opcode_t op;
    int      hit;

    rst = 1'b1; opcode = OP_I_TYPE; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs",
          {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
           alu_a_sel, alu_b_sel, rf_we, wb_sel, instr_done, illegal}, 0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    check("imem_req_after_rst", 32'(imem_req), 1);

    check_instr(OP_I_TYPE, 1'b0, 0, 0);
    check_instr(OP_LOAD,   1'b0, 0, 3);
    check_instr(OP_STORE,  1'b0, 0, 0);
    check_instr(OP_BRANCH, 1'b1, 0, 0);
    check_instr(OP_BRANCH, 1'b0, 0, 0);
    check_instr(OP_JALR,   1'b0, 0, 0);
    check_instr(OP_JAL,    1'b0, 2, 0);
    check_instr(OP_LUI,    1'b0, 0, 0);
    check_instr(OP_AUIPC,  1'b0, 1, 0);
    check_instr(OP_R_TYPE, 1'b0, 0, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    check_instr(7'h00,     1'b0, 0, 0);
`endif

    // Reset in the middle of a stalled load.
    @(negedge clk);
    opcode = OP_LOAD; imem_ready = 1'b1; dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < 10 && !dmem_req; i++) begin
      @(negedge clk);
      #1;
    end
    check("mem_reached", 32'(dmem_req), 1);
    rst = 1'b1;
    #1;
    check("rst_drops_dmem_req", 32'(dmem_req), 0);
    check("rst_drops_imem_req", 32'(imem_req), 0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    check("fetch_after_mem_rst", {imem_req, dmem_req}, 2'b10);

    for (int n = 0; n < 60; n++) begin
      int k = $urandom_range(0, 9);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (k == 9) k = 0;
`endif
      op = (k == 9) ? odd[$urandom_range(0, 3)] : legal[k];
      check_instr(op, 1'($urandom % 2), $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    opcode = 7'h00; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    for (int i = 0; i < 10 && !illegal; i++) begin
      @(negedge clk);
      #1;
    end
    check("trap_illegal", 32'(illegal), 1);
    hit = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (imem_req || dmem_req || instr_done || pc_we || rf_we || !illegal) hit++;
    end
    check("trap_quiet", hit, 0);
    rst = 1'b1;
    #1;
    check("trap_rst_clears", 32'(illegal), 0);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0;
    #1;
    check("trap_exit_fetch", 32'(imem_req), 1);
    check_instr(OP_I_TYPE, 1'b0, 0, 0);
`else
    hit = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
